// File: rtl/bsg_counter_dynamic_limit_down.sv
// Down-counting timer that loads a limit over a valid/ready handshake and pulses
// expire_o one cycle after the count reaches zero on an enabled cycle.
module bsg_counter_dynamic_limit_down #(
    parameter int width_p  = 32,
    parameter bit reload_p = 1'b1
) (
    input  logic               clk_i,
    input  logic               reset_n_i,
    input  logic               limit_v_i,
    input  logic [width_p-1:0] limit_i,
    output logic               limit_ready_o,
    input  logic               en_i,
    input  logic               clear_i,
    output logic [width_p-1:0] counter_o,
    output logic               expire_o,
    output logic               busy_o
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    logic [0:0]         state_q,   state_d;
    logic [width_p-1:0] counter_q, counter_d;
    logic [width_p-1:0] limit_q,   limit_d;
    logic               expire_q,  expire_d;
    logic               accept;

    // In periodic mode a new limit may be queued while running; one-shot only loads from IDLE.
    assign limit_ready_o = ~clear_i & ((state_q == IDLE) | reload_p);
    assign accept        = limit_v_i & limit_ready_o;

    always_comb begin
        // NOTE: every next-state signal gets a default first so no path leaves it unassigned (no latches).
        state_d   = state_q;
        counter_d = counter_q;
        limit_d   = limit_q;
        expire_d  = 1'b0;

        if (clear_i) begin
            state_d   = IDLE;
            counter_d = '0;
        end else begin
            if (accept) begin
                limit_d = limit_i;
            end

            case (state_q)
                IDLE: begin
                    if (accept) begin
                        counter_d = limit_i;
                        state_d   = RUN;
                    end
                end
                RUN: begin
                    if (en_i) begin
                        if (counter_q != '0) begin
                            counter_d = counter_q - width_p'(1);
                        end else begin
                            expire_d = 1'b1;
                            if (reload_p) begin
                                // A limit arriving on the expiry cycle is used immediately.
                                counter_d = accept ? limit_i : limit_q;
                            end else begin
                                state_d = IDLE;
                            end
                        end
                    end
                end
                default: begin
                    state_d   = IDLE;
                    counter_d = '0;
                end
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q   <= IDLE;
            counter_q <= '0;
            limit_q   <= '0;
            expire_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            counter_q <= counter_d;
            limit_q   <= limit_d;
            expire_q  <= expire_d;
        end
    end

    assign counter_o = counter_q;
    assign expire_o  = expire_q;
    assign busy_o    = (state_q == RUN);

endmodule

// File: tb/tb_bsg_counter_dynamic_limit_down.sv
// Bench for the down-counting timer: one one-shot and one periodic instance driven
// by shared stimulus, each compared every cycle against a behavioural model.
module tb_bsg_counter_dynamic_limit_down;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         limit_v = 1'b0;
    logic [W-1:0] limit_in = '0;
    logic         en = 1'b0;
    logic         clear = 1'b0;

    logic [W-1:0] counter [2];
    logic         expire  [2];
    logic         busy    [2];
    logic         ready   [2];

    int passed = 0;
    int total  = 0;
    bit chk_en = 1'b0;

    // index 0: one-shot, index 1: periodic
    bit rel   [2] = '{1'b0, 1'b1};
    bit m_run [2];
    bit m_exp [2];
    int m_cnt [2];
    int m_lim [2];

    always #5 clk = ~clk;

    bsg_counter_dynamic_limit_down #(.width_p(W), .reload_p(1'b0)) u_os (
        .clk_i        (clk),
        .reset_n_i    (rst_n),
        .limit_v_i    (limit_v),
        .limit_i      (limit_in),
        .limit_ready_o(ready[0]),
        .en_i         (en),
        .clear_i      (clear),
        .counter_o    (counter[0]),
        .expire_o     (expire[0]),
        .busy_o       (busy[0])
    );

    bsg_counter_dynamic_limit_down #(.width_p(W), .reload_p(1'b1)) u_pr (
        .clk_i        (clk),
        .reset_n_i    (rst_n),
        .limit_v_i    (limit_v),
        .limit_i      (limit_in),
        .limit_ready_o(ready[1]),
        .en_i         (en),
        .clear_i      (clear),
        .counter_o    (counter[1]),
        .expire_o     (expire[1]),
        .busy_o       (busy[1])
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    function automatic bit model_ready(input int k);
        return !clear && (!m_run[k] || rel[k]);
    endfunction

    // Behavioural model: a timer either idles or runs a countdown toward zero.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 2; k++) begin
                m_run[k] = 1'b0; m_exp[k] = 1'b0; m_cnt[k] = 0; m_lim[k] = 0;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                bit acc;
                acc      = limit_v && model_ready(k);
                m_exp[k] = 1'b0;
                if (clear) begin
                    m_run[k] = 1'b0;
                    m_cnt[k] = 0;
                end else if (!m_run[k]) begin
                    if (acc) begin
                        m_cnt[k] = int'(limit_in);
                        m_run[k] = 1'b1;
                    end
                end else if (en) begin
                    if (m_cnt[k] > 0) begin
                        m_cnt[k] = m_cnt[k] - 1;
                    end else begin
                        m_exp[k] = 1'b1;
                        if (rel[k]) m_cnt[k] = acc ? int'(limit_in) : m_lim[k];
                        else        m_run[k] = 1'b0;
                    end
                end
                if (acc) m_lim[k] = int'(limit_in);
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en && rst_n) begin
            for (int k = 0; k < 2; k++) begin
                check($sformatf("model counter[%0d]", k), 32'(counter[k]), 32'(m_cnt[k]));
                check($sformatf("model expire[%0d]", k),  32'(expire[k]),  32'(m_exp[k]));
                check($sformatf("model busy[%0d]", k),    32'(busy[k]),    32'(m_run[k]));
                check($sformatf("model ready[%0d]", k),   32'(ready[k]),   32'(model_ready(k)));
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int pr_cnt [5] = '{2, 1, 0, 3, 2};
        int pr_exp [5] = '{0, 0, 0, 1, 0};
        int os_cnt [5] = '{2, 1, 0, 0, 0};
        int os_exp [5] = '{0, 0, 0, 1, 0};
        int os_bsy [5] = '{1, 1, 1, 0, 0};

        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        chk_en = 1'b1;
        for (int k = 0; k < 2; k++) begin
            check($sformatf("reset counter[%0d]", k), 32'(counter[k]), 0);
            check($sformatf("reset expire[%0d]", k),  32'(expire[k]),  0);
            check($sformatf("reset busy[%0d]", k),    32'(busy[k]),    0);
            check($sformatf("reset ready[%0d]", k),   32'(ready[k]),   1);
        end

        // Load 3 with enable held: periodic wraps every 4 cycles, one-shot stops once.
        limit_v = 1'b1; limit_in = 8'd3; en = 1'b1;
        cyc();
        limit_v = 1'b0;
        check("load3 pr counter", 32'(counter[1]), 3);
        check("load3 os counter", 32'(counter[0]), 3);
        check("load3 pr busy",    32'(busy[1]),    1);
        for (int i = 0; i < 5; i++) begin
            cyc();
            check($sformatf("seq pr counter %0d", i), 32'(counter[1]), 32'(pr_cnt[i]));
            check($sformatf("seq pr expire %0d", i),  32'(expire[1]),  32'(pr_exp[i]));
            check($sformatf("seq os counter %0d", i), 32'(counter[0]), 32'(os_cnt[i]));
            check($sformatf("seq os expire %0d", i),  32'(expire[0]),  32'(os_exp[i]));
            check($sformatf("seq os busy %0d", i),    32'(busy[0]),    32'(os_bsy[i]));
        end
        check("os ready after expiry", 32'(ready[0]), 1);

        // Clear blocks the handshake and returns both to IDLE.
        clear = 1'b1; limit_v = 1'b1; limit_in = 8'd9;
        #1;
        check("clear ready os", 32'(ready[0]), 0);
        check("clear ready pr", 32'(ready[1]), 0);
        cyc();
        clear = 1'b0; limit_v = 1'b0;
        check("clear pr counter", 32'(counter[1]), 0);
        check("clear pr busy",    32'(busy[1]),    0);
        check("clear pr expire",  32'(expire[1]),  0);

        // Limit 0 in periodic mode expires every enabled cycle.
        limit_v = 1'b1; limit_in = 8'd0;
        cyc();
        limit_v = 1'b0;
        check("zero pr busy",   32'(busy[1]),   1);
        check("zero pr expire", 32'(expire[1]), 0);
        repeat (3) begin
            cyc();
            check("zero pr expire pulse", 32'(expire[1]),  1);
            check("zero pr counter",      32'(counter[1]), 0);
        end

        // Queued limit during countdown, enable held low at zero, then bypass reload.
        clear = 1'b1;
        cyc();
        clear = 1'b0; limit_v = 1'b1; limit_in = 8'd5;
        cyc();
        limit_v = 1'b0;
        repeat (3) cyc();
        check("q pr counter 2", 32'(counter[1]), 2);
        limit_v = 1'b1; limit_in = 8'd7;
        cyc();
        limit_v = 1'b0;
        check("q pr counter 1", 32'(counter[1]), 1);
        cyc();
        check("q pr counter 0", 32'(counter[1]), 0);
        en = 1'b0;
        repeat (2) begin
            cyc();
            check("hold pr counter", 32'(counter[1]), 0);
            check("hold pr expire",  32'(expire[1]),  0);
        end
        en = 1'b1;
        cyc();
        check("reload pr counter 7", 32'(counter[1]), 7);
        check("reload pr expire",    32'(expire[1]),  1);
        repeat (7) cyc();
        check("bypass pr pre counter", 32'(counter[1]), 0);
        limit_v = 1'b1; limit_in = 8'd9;
        cyc();
        limit_v = 1'b0;
        check("bypass pr counter 9", 32'(counter[1]), 9);
        check("bypass pr expire",    32'(expire[1]),  1);

        // Full-range limit, then async reset mid-count.
        clear = 1'b1;
        cyc();
        clear = 1'b0; limit_v = 1'b1; limit_in = 8'd255;
        cyc();
        limit_v = 1'b0;
        check("max os counter", 32'(counter[0]), 255);
        check("max pr counter", 32'(counter[1]), 255);
        cyc();
        #2 rst_n = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            check($sformatf("async counter[%0d]", k), 32'(counter[k]), 0);
            check($sformatf("async busy[%0d]", k),    32'(busy[k]),    0);
            check($sformatf("async expire[%0d]", k),  32'(expire[k]),  0);
        end
        cyc();
        rst_n = 1'b1;

        // Randomised phase, checked every cycle against the model.
        repeat (3000) begin
            clear   = ($urandom_range(0, 19) == 0);
            limit_v = ($urandom_range(0, 3) == 0);
            case ($urandom_range(0, 3))
                0:       limit_in = '0;
                1:       limit_in = '1;
                2:       limit_in = W'($urandom_range(0, 6));
                default: limit_in = W'($urandom);
            endcase
            en = ($urandom_range(0, 3) != 0);
            cyc();
            if ($urandom_range(0, 499) == 0) begin
                #2 rst_n = 1'b0;
                #1 rst_n = 1'b1;
            end
        end

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
